ex_mdu_sched: RTL
=================

// Module: ex_mdu_sched
// PURPOSE
// - Sequences the EX-stage multi-cycle multiplier and divider: issues start pulses, waits for done,
//   captures and formats the result, and drives the EX stall request until the result is accepted.
// - Resolves divide-by-zero and signed overflow without starting the divider. Handles flush aborts and
//   sub-unit hangs. Sits between ex and the multiplier/divider instances.
// PARAMETERS
// - XLEN         64    datapath width
// - TIMEOUT_CYC  128   max cycles in a WAIT state before forced abort
// - CNT_W        8     width of the timeout counter; must hold TIMEOUT_CYC
// PORTS
// - clk          in   1     clock, all state on posedge
// - rst          in   1     async active-high reset
// - req_valid    in   1     EX holds an M-extension op
// - req_op       in   4     MDU_OP_* code: MUL,MULH,MULHSU,MULHU,MULW,DIV,DIVU,DIVW,DIVUW,REM,REMU,REMW,REMUW
// - req_op1/2    in   XLEN  rs1/rs2 values
// - req_kill     in   1     EX flush; abort the current op
// - stall_in     in   1     downstream stall; hold the result
// - mul_start    out  1     one-cycle start pulse to multiplier
// - mul_op       out  4     registered op code to multiplier
// - mul_a/mul_b  out  XLEN  registered, pre-formatted operands
// - mul_done     in   1     multiplier result valid, one cycle
// - mul_res      in   XLEN  multiplier result
// - div_start    out  1     one-cycle start pulse to divider
// - div_signed   out  1     signed division
// - div_a/div_b  out  XLEN  dividend/divisor, registered
// - div_done     in   1     divider result valid, one cycle
// - div_quot     in   XLEN  divider quotient
// - div_rem      in   XLEN  divider remainder
// - resp_valid   out  1     result valid (state DONE)
// - resp_data    out  XLEN  formatted result
// - stall_req    out  1     to ctrl: hold the pipeline
// - busy         out  1     state != IDLE
// - err_timeout  out  1     sticky; set on a timeout abort, cleared only by rst
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0, including the registered operands and the timeout counter.
// - FSM states: IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN.
// - IDLE, req_valid & ~req_kill:
//   - mul op -> MUL_WAIT; mul_start=1 for exactly the first cycle of MUL_WAIT.
//   - div/rem, normal case -> DIV_WAIT; div_start=1 for the first cycle of DIV_WAIT.
//   - div/rem special case -> DONE directly; resp_valid is seen at N+1.
// - Special cases (*W variants evaluated at 32 bits):
//   - divisor==0: quot=all ones, rem=dividend.
//   - signed MIN / -1: quot=MIN, rem=0.
// - Operand prep:
//   - W div signed: sign-extend the low 32 bits of each operand.
//   - W div unsigned: zero-extend the low 32 bits.
//   - MULW: pass the low 32 bits.
// - Result formatting:
//   - every *W result = sign-extended bit 31.
//   - MULH/MULHSU/MULHU take the upper word, which the multiplier returns in mul_res.
// - MUL_WAIT/DIV_WAIT:
//   - on done, latch the formatted result -> DONE.
//   - counter increments each cycle.
//   - count==TIMEOUT_CYC-1 without done -> resp_data=0, set err_timeout, go to DONE.
// - DONE: resp_valid=1. ~stall_in -> IDLE at the next edge (result consumed). stall_in -> stay, data stable.
// - req_kill in MUL_WAIT/DIV_WAIT -> DRAIN. DRAIN waits for the pending done (or timeout), discards it, -> IDLE.
// - req_kill in DONE -> IDLE; result dropped.
// - req_kill in IDLE -> no start.
// - req_kill wins over a same-cycle done.
// - stall_req = req_valid & ~req_kill & ~(state==DONE), plus 1 while in DRAIN. Combinational.
// - New requests are accepted only in IDLE; done pulses arriving in IDLE are ignored.
// - Async rst mid-operation: immediate return to IDLE, all outputs 0.
// STRUCTURE
// - Shared defines file: MDU_OP_* codes (4 bits), FSM state encodings, MDU_OPC_IS_W/IS_DIV/IS_SIGNED helpers.
// - Sub-module mdu_div_special: combinational detection and results for divide-by-zero and overflow.
// - FSM, counter and result register stay in ex_mdu_sched.
// TESTING
// - MUL, op1=3, op2=-5, done after 4 cycles:
//   start pulse 1 cycle; stall_req high until DONE; resp_data=0xFFFFFFFFFFFFFFF1.
// - DIVW, op1=0x00000000_FFFFFFF9 (-7), op2=2, div_quot=-3:
//   div_a=sext(-7); resp_data=0xFFFFFFFFFFFFFFFD.
// - REMU, op2=0, op1=0x1234:
//   no div_start; resp_valid at N+1; resp_data=0x1234.
//   Also DIV 0x8000000000000000 / -1 -> resp_data=0x8000000000000000.
// - DIV started, req_kill 2 cycles later:
//   enters DRAIN; late div_done discarded; resp_valid never 1; returns to IDLE, then accepts a new MUL.
// - DONE with stall_in=1 for 3 cycles:
//   resp_data stable; IDLE one cycle after stall_in drops.
//   Also assert rst in MUL_WAIT -> all outputs 0 immediately.
// - Divider never returns done:
//   after TIMEOUT_CYC cycles, err_timeout=1, resp_data=0, FSM reaches IDLE.

Source files
------------

// File: rtl/ex_mdu_sched_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the EX-stage MDU scheduler.
package ex_mdu_sched_pkg;

    localparam logic [3:0] MDU_OP_MUL    = 4'd0;
    localparam logic [3:0] MDU_OP_MULH   = 4'd1;
    localparam logic [3:0] MDU_OP_MULHSU = 4'd2;
    localparam logic [3:0] MDU_OP_MULHU  = 4'd3;
    localparam logic [3:0] MDU_OP_MULW   = 4'd4;
    localparam logic [3:0] MDU_OP_DIV    = 4'd5;
    localparam logic [3:0] MDU_OP_DIVU   = 4'd6;
    localparam logic [3:0] MDU_OP_DIVW   = 4'd7;
    localparam logic [3:0] MDU_OP_DIVUW  = 4'd8;
    localparam logic [3:0] MDU_OP_REM    = 4'd9;
    localparam logic [3:0] MDU_OP_REMU   = 4'd10;
    localparam logic [3:0] MDU_OP_REMW   = 4'd11;
    localparam logic [3:0] MDU_OP_REMUW  = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_DONE     = 3'd3,
        ST_DRAIN    = 3'd4
    } mdu_state_e;

    function automatic logic mdu_opc_is_mul(input logic [3:0] op);
        return op <= MDU_OP_MULW;
    endfunction

    function automatic logic mdu_opc_is_div(input logic [3:0] op);
        return (op >= MDU_OP_DIV) && (op <= MDU_OP_REMUW);
    endfunction

    function automatic logic mdu_opc_is_rem(input logic [3:0] op);
        return (op >= MDU_OP_REM) && (op <= MDU_OP_REMUW);
    endfunction

    function automatic logic mdu_opc_is_w(input logic [3:0] op);
        return (op == MDU_OP_MULW) || (op == MDU_OP_DIVW) || (op == MDU_OP_DIVUW) ||
               (op == MDU_OP_REMW) || (op == MDU_OP_REMUW);
    endfunction

    function automatic logic mdu_opc_is_signed(input logic [3:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVW) ||
               (op == MDU_OP_REM) || (op == MDU_OP_REMW);
    endfunction

endpackage

// File: rtl/ex_mdu_sched_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the architectural result.
module mdu_div_special #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_signed,
    input  logic            i_w,
    input  logic            i_rem,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    logic w_b_zero;
    logic w_ovf;

    always_comb begin
        w_b_zero = 1'b0;
        w_ovf    = 1'b0;
        if (i_w) begin
            w_b_zero = (i_b[31:0] == 32'd0);
            w_ovf    = i_signed && (i_a[31:0] == 32'h8000_0000) && (i_b[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_b_zero = (i_b == '0);
            w_ovf    = i_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
        end
    end

    // Operands arrive already extended, so the dividend doubles as MIN for the overflow quotient.
    always_comb begin
        o_special = w_b_zero | w_ovf;
        o_result  = '0;
        if (w_b_zero) begin
            o_result = i_rem ? i_a : '1;
        end else if (w_ovf) begin
            o_result = i_rem ? '0 : i_a;
        end
    end

endmodule

// File: rtl/ex_mdu_sched.sv
// EX-stage multiply/divide sequencer: start pulses, done wait, result formatting, stall and abort.
module ex_mdu_sched
    import ex_mdu_sched_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 128,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    input  logic            req_kill,
    input  logic            stall_in,
    output logic            mul_start,
    output logic [3:0]      mul_op,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_res,
    output logic            div_start,
    output logic            div_signed,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            stall_req,
    output logic            busy,
    output logic            err_timeout
);

    mdu_state_e      r_state;
    mdu_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]      r_op;
    logic [3:0]      r_mul_op;
    logic [XLEN-1:0] r_mul_a;
    logic [XLEN-1:0] r_mul_b;
    logic            r_div_signed;
    logic [XLEN-1:0] r_div_a;
    logic [XLEN-1:0] r_div_b;
    logic [XLEN-1:0] r_resp_data;
    logic            r_err_timeout;

    logic            w_accept;
    logic            w_req_mul;
    logic            w_req_div;
    logic [XLEN-1:0] w_op1_prep;
    logic [XLEN-1:0] w_op2_prep;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_pend_done;
    logic            w_timeout;
    logic [XLEN-1:0] w_raw_res;

    function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    assign w_accept  = req_valid & ~req_kill;
    assign w_req_mul = mdu_opc_is_mul(req_op);
    assign w_req_div = mdu_opc_is_div(req_op);

    // W divides extend per signedness; MULW hands the multiplier only the low word.
    always_comb begin
        w_op1_prep = req_op1;
        w_op2_prep = req_op2;
        if (mdu_opc_is_w(req_op)) begin
            if (w_req_div && mdu_opc_is_signed(req_op)) begin
                w_op1_prep = {{(XLEN-32){req_op1[31]}}, req_op1[31:0]};
                w_op2_prep = {{(XLEN-32){req_op2[31]}}, req_op2[31:0]};
            end else begin
                w_op1_prep = {{(XLEN-32){1'b0}}, req_op1[31:0]};
                w_op2_prep = {{(XLEN-32){1'b0}}, req_op2[31:0]};
            end
        end
    end

    mdu_div_special #(
        .XLEN(XLEN)
    ) u_div_special (
        .i_a      (w_op1_prep),
        .i_b      (w_op2_prep),
        .i_signed (mdu_opc_is_signed(req_op)),
        .i_w      (mdu_opc_is_w(req_op)),
        .i_rem    (mdu_opc_is_rem(req_op)),
        .o_special(w_special),
        .o_result (w_special_res)
    );

    assign w_pend_done = mdu_opc_is_div(r_op) ? div_done : mul_done;
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_raw_res   = mdu_opc_is_div(r_op) ? (mdu_opc_is_rem(r_op) ? div_rem : div_quot) : mul_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_mul) begin
                        w_state_next = ST_MUL_WAIT;
                    end else if (w_req_div && !w_special) begin
                        w_state_next = ST_DIV_WAIT;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_MUL_WAIT, ST_DIV_WAIT: begin
                // A kill coinciding with done/timeout has nothing left to drain.
                if (req_kill) begin
                    w_state_next = (w_pend_done || w_timeout) ? ST_IDLE : ST_DRAIN;
                end else if (w_pend_done || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (req_kill || !stall_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_pend_done || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_start  = (r_state == ST_MUL_WAIT) && (r_cnt == '0);
        div_start  = (r_state == ST_DIV_WAIT) && (r_cnt == '0);
        resp_valid = (r_state == ST_DONE);
        busy       = (r_state != ST_IDLE);
        stall_req  = ~rst & ((req_valid & ~req_kill & (r_state != ST_DONE)) | (r_state == ST_DRAIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_op          <= '0;
            r_mul_op      <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_div_signed  <= 1'b0;
            r_div_a       <= '0;
            r_div_b       <= '0;
            r_resp_data   <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= req_op;
                        r_cnt <= '0;
                        if (w_req_mul) begin
                            r_mul_op <= req_op;
                            r_mul_a  <= w_op1_prep;
                            r_mul_b  <= w_op2_prep;
                        end else if (w_req_div) begin
                            r_div_signed <= mdu_opc_is_signed(req_op);
                            r_div_a      <= w_op1_prep;
                            r_div_b      <= w_op2_prep;
                            if (w_special) begin
                                r_resp_data <= fmt_w(w_special_res, mdu_opc_is_w(req_op));
                            end
                        end else begin
                            r_resp_data <= '0;
                        end
                    end
                end
                ST_MUL_WAIT, ST_DIV_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!req_kill && w_pend_done) begin
                        r_resp_data <= fmt_w(w_raw_res, mdu_opc_is_w(r_op));
                    end else if (w_timeout && !w_pend_done) begin
                        r_err_timeout <= 1'b1;
                        if (!req_kill) begin
                            r_resp_data <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout && !w_pend_done) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_op      = r_mul_op;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign div_signed  = r_div_signed;
    assign div_a       = r_div_a;
    assign div_b       = r_div_b;
    assign resp_data   = r_resp_data;
    assign err_timeout = r_err_timeout;

endmodule
